// File: rtl/headstrip_in_demux.sv
// headstrip_in_demux: strips prefix, captures two 16-bit header fields (MSB first) and forwards the payload of sof/eof framed bytes.
//   Ports: clk, rst (sync, active-high); in_data[7:0], in_valid, in_sof, in_eof (byte stream in);
//   out_data[7:0], out_valid, out_sof, out_eof, out_abort (payload out, 1-cycle latency);
//   field_0[15:0], field_1[15:0], hdr_valid, hdr_err (header capture and status pulses).
//   Build option HEADSTRIP_CHECK_EN: compare prefix bytes to PRE_VALUE and drop mismatching frames.
module headstrip_in_demux #(
  parameter int          PRE_BYTES = 2,
  parameter logic [15:0] PRE_VALUE = 16'h0102
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_abort,
  output logic [15:0] field_0,
  output logic [15:0] field_1,
  output logic        hdr_valid,
  output logic        hdr_err
);
`ifdef HEADSTRIP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, PREFIX, FIELD, PAYLOAD, DROP} state_t;
  state_t      state_q, state_d, hstate;
  logic [2:0]  cnt_q, cnt_d, idx;
  logic [15:0] f0_q, f0_d, f1_q, f1_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic        abort_q, abort_d, hv_q, hv_d, err_q, err_d;
  logic        last_pre, mismatch;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    abort_d  = 1'b0;
    hv_d     = 1'b0;
    err_d    = 1'b0;
    // a sof byte always restarts parsing as header byte 0, whatever the current state
    hstate   = in_sof ? ((PRE_BYTES > 0) ? PREFIX : FIELD) : state_q;
    idx      = in_sof ? 3'd0 : cnt_q;
    last_pre = (int'(idx) == PRE_BYTES - 1);
    mismatch = CHECK_EN && (in_data != (idx[0] ? PRE_VALUE[7:0] : PRE_VALUE[15:8]));
    if (in_valid) begin
      abort_d = in_sof && state_q == PAYLOAD;
      err_d   = in_sof && (state_q == PREFIX || state_q == FIELD);
      if (hstate == PREFIX) begin
        if (mismatch || in_eof) begin
          err_d   = 1'b1;
          state_d = (mismatch && !in_eof) ? DROP : IDLE;
        end else begin
          state_d = last_pre ? FIELD : PREFIX;
          cnt_d   = last_pre ? 3'd0 : idx + 3'd1;
        end
      end else if (hstate == FIELD) begin
        if (idx[1:0] == 2'd0) f0_d[15:8] = in_data;
        if (idx[1:0] == 2'd1) f0_d[7:0]  = in_data;
        if (idx[1:0] == 2'd2) f1_d[15:8] = in_data;
        if (idx[1:0] == 2'd3) f1_d[7:0]  = in_data;
        if (idx == 3'd3) begin
          hv_d    = 1'b1;
          state_d = in_eof ? IDLE : PAYLOAD;
          cnt_d   = 3'd0;
        end else if (in_eof) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FIELD;
          cnt_d   = idx + 3'd1;
        end
      end else if (hstate == PAYLOAD) begin
        // cnt_q==0 marks the first payload byte; it saturates at 1 afterwards
        data_d  = in_data;
        valid_d = 1'b1;
        sof_d   = cnt_q == 3'd0;
        eof_d   = in_eof;
        cnt_d   = 3'd1;
        state_d = in_eof ? IDLE : PAYLOAD;
      end else if (hstate == DROP && in_eof) begin
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f0_q    <= '0;
      f1_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      abort_q <= 1'b0;
      hv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      abort_q <= abort_d;
      hv_q    <= hv_d;
      err_q   <= err_d;
    end
  end
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign out_abort = abort_q;
  assign field_0   = f0_q;
  assign field_1   = f1_q;
  assign hdr_valid = hv_q;
  assign hdr_err   = err_q;
endmodule

// File: tb/tb_headstrip_in_demux.sv
// tb_headstrip_in_demux: table-driven directed bench for headstrip_in_demux (PRE_BYTES=2, PRE_VALUE=16'h0102).
module tb_headstrip_in_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_sof, in_eof;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_abort;
  logic [15:0] field_0, field_1;
  logic        hdr_valid, hdr_err;
  int checks = 0;
  int failures = 0;
  localparam logic [5:0] OV = 6'b100000, OS = 6'b010000, OE = 6'b001000;
  localparam logic [5:0] AB = 6'b000100, HV = 6'b000010, HE = 6'b000001, NO = 6'b000000;
  typedef struct {
    logic        v, s, e;
    logic [7:0]  d;
    logic [5:0]  x;
    logic [15:0] f0, f1;
  } vec_t;
  vec_t tbl[$];
  headstrip_in_demux dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_abort(out_abort),
    .field_0(field_0), .field_1(field_1), .hdr_valid(hdr_valid), .hdr_err(hdr_err)
  );
  always #5 clk = ~clk;
  task automatic push(input logic v, input logic s, input logic e, input logic [7:0] d, input logic [5:0] x,
                      input logic [15:0] f0 = 16'h0405, input logic [15:0] f1 = 16'h0607);
    tbl.push_back('{v, s, e, d, x, f0, f1});
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 8'h00, NO);
  endtask
  task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_eof   = e;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [5:0] x, input logic [7:0] d, input logic [15:0] f0, input logic [15:0] f1);
    logic [5:0] act;
    act = {out_valid, out_sof, out_eof, out_abort, hdr_valid, hdr_err};
    checks++;
    if (act !== x) begin
      failures++;
      $display("FAIL %s flags {ov,os,oe,ab,hv,he} got=%b want=%b", name, act, x);
    end
    if (x[5]) begin
      checks++;
      if (out_data !== d) begin
        failures++;
        $display("FAIL %s out_data got=%h want=%h", name, out_data, d);
      end
    end
    if (x[1]) begin
      checks++;
      if (field_0 !== f0 || field_1 !== f1) begin
        failures++;
        $display("FAIL %s fields got=%h/%h want=%h/%h", name, field_0, field_1, f0, f1);
      end
    end
  endtask
  task automatic frame_hdr();
    push(1, 1, 0, 8'h01, NO);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'h04, NO);
    push(1, 0, 0, 8'h05, NO);
    push(1, 0, 0, 8'h06, NO);
    push(1, 0, 0, 8'h07, HV);
  endtask
  task automatic frame_pay();
    push(1, 0, 0, 8'hA1, OV | OS);
    push(1, 0, 0, 8'hB2, OV);
    push(1, 0, 0, 8'hC3, OV);
    push(1, 0, 0, 8'hD4, OV);
    push(1, 0, 1, 8'hE5, OV | OE);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_eof = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", NO, 8'h00, 16'h0, 16'h0);
    checks++;
    if (out_data !== 8'h00 || field_0 !== 16'h0 || field_1 !== 16'h0) begin
      failures++;
      $display("FAIL reset_values data=%h f0=%h f1=%h want 0", out_data, field_0, field_1);
    end
    rst = 1'b0;
    // 1: back-to-back frame, then an idle cycle
    frame_hdr();
    frame_pay();
    gap(1);
    // 2: same frame with 3-cycle gaps between 05/06 and B2/C3
    push(1, 1, 0, 8'h01, NO);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'h04, NO);
    push(1, 0, 0, 8'h05, NO);
    gap(3);
    push(1, 0, 0, 8'h06, NO);
    push(1, 0, 0, 8'h07, HV);
    push(1, 0, 0, 8'hA1, OV | OS);
    push(1, 0, 0, 8'hB2, OV);
    gap(3);
    push(1, 0, 0, 8'hC3, OV);
    push(1, 0, 0, 8'hD4, OV);
    push(1, 0, 1, 8'hE5, OV | OE);
    // 3: truncated header, then a frame with other fields and a single-byte payload
    push(1, 1, 0, 8'h01, NO);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'h04, NO);
    push(1, 0, 1, 8'h05, HE);
    gap(1);
    push(1, 1, 0, 8'h01, NO);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'h11, NO);
    push(1, 0, 0, 8'h22, NO);
    push(1, 0, 0, 8'h33, NO);
    push(1, 0, 0, 8'h44, HV, 16'h1122, 16'h3344);
    push(1, 0, 1, 8'h55, OV | OS | OE);
    // stray byte in IDLE is discarded
    push(1, 0, 0, 8'h77, NO);
    // 4: sof on the third payload byte restarts the frame
    frame_hdr();
    push(1, 0, 0, 8'hA1, OV | OS);
    push(1, 0, 0, 8'hB2, OV);
    push(1, 1, 0, 8'h01, AB);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'h04, NO);
    push(1, 0, 0, 8'h05, NO);
    push(1, 0, 0, 8'h06, NO);
    push(1, 0, 0, 8'h07, HV);
    frame_pay();
    // 5: wrong prefix byte
    push(1, 1, 0, 8'h01, NO);
`ifdef HEADSTRIP_CHECK_EN
    push(1, 0, 0, 8'h03, HE);
    push(1, 0, 0, 8'h04, NO);
    push(1, 0, 0, 8'h05, NO);
    push(1, 0, 0, 8'h06, NO);
    push(1, 0, 0, 8'h07, NO);
    push(1, 0, 0, 8'hA1, NO);
    push(1, 0, 1, 8'hE5, NO);
`else
    push(1, 0, 0, 8'h03, NO);
    push(1, 0, 0, 8'h04, NO);
    push(1, 0, 0, 8'h05, NO);
    push(1, 0, 0, 8'h06, NO);
    push(1, 0, 0, 8'h07, HV);
    frame_pay();
`endif
    // 1-byte frame (sof+eof) is a truncated header
    push(1, 1, 1, 8'h01, HE);
    // sof inside FIELD: hdr_err and restart; fields overwritten by the new frame
    push(1, 1, 0, 8'h01, NO);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'h99, NO);
    push(1, 1, 0, 8'h01, HE);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'h04, NO);
    push(1, 0, 0, 8'h05, NO);
    push(1, 0, 0, 8'h06, NO);
    push(1, 0, 0, 8'h07, HV);
    push(1, 0, 1, 8'hA1, OV | OS | OE);
    // eof on the last field byte: header valid, no payload, back to IDLE
    push(1, 1, 0, 8'h01, NO);
    push(1, 0, 0, 8'h02, NO);
    push(1, 0, 0, 8'hAB, NO);
    push(1, 0, 0, 8'hCD, NO);
    push(1, 0, 0, 8'hEF, NO);
    push(1, 0, 1, 8'h12, HV, 16'hABCD, 16'hEF12);
    push(1, 0, 0, 8'h66, NO);
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].x, tbl[i].d, tbl[i].f0, tbl[i].f1);
    end
    // 6: reset for one cycle mid-payload
    step(1, 1, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    step(1, 0, 0, 8'h04);
    step(1, 0, 0, 8'h05);
    step(1, 0, 0, 8'h06);
    step(1, 0, 0, 8'h07);
    chk("rst_hdr", HV, 8'h00, 16'h0405, 16'h0607);
    step(1, 0, 0, 8'hA1);
    chk("rst_a1", OV | OS, 8'hA1, 16'h0, 16'h0);
    rst = 1'b1;
    step(1, 0, 0, 8'hB2);
    rst = 1'b0;
    chk("rst_out", NO, 8'h00, 16'h0, 16'h0);
    checks++;
    if (out_data !== 8'h00 || field_0 !== 16'h0 || field_1 !== 16'h0) begin
      failures++;
      $display("FAIL rst_values data=%h f0=%h f1=%h want 0", out_data, field_0, field_1);
    end
    step(1, 0, 0, 8'hC3);
    chk("rst_c3", NO, 8'h00, 16'h0, 16'h0);
    step(1, 0, 1, 8'hD4);
    chk("rst_d4", NO, 8'h00, 16'h0, 16'h0);
    step(1, 1, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    step(1, 0, 0, 8'h21);
    step(1, 0, 0, 8'h43);
    step(1, 0, 0, 8'h65);
    step(1, 0, 0, 8'h87);
    chk("rst_new_hdr", HV, 8'h00, 16'h2143, 16'h6587);
    step(1, 0, 1, 8'h5A);
    chk("rst_new_pay", OV | OS | OE, 8'h5A, 16'h0, 16'h0);
    step(0, 0, 0, 8'h00);
    chk("rst_idle", NO, 8'h00, 16'h0, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
